// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if: W-stage retire, host loader and register-file write bundle.
// The scheduler takes the slave view; the producer side takes the master view.
interface wb_port_scheduler_if;
  logic        W_valid;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        w_ready;
  logic        host_req;
  logic [3:0]  host_addr;
  logic [63:0] host_data;
  logic        host_ack;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        halted;

  modport master (
    output W_valid, W_stat, W_icode, W_dstE, W_dstM,
    output W_valE, W_valM,
    output host_req, host_addr, host_data,
    input  w_ready, host_ack,
    input  rf_we, rf_waddr, rf_wdata, halted
  );

  modport slave (
    input  W_valid, W_stat, W_icode, W_dstE, W_dstM,
    input  W_valE, W_valM,
    input  host_req, host_addr, host_data,
    output w_ready, host_ack,
    output rf_we, rf_waddr, rf_wdata, halted
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: single write-port sequencer for the Y86-64 register file.
// Arbitrates W-stage retirement, popq split writes and host loader writes.
module wb_port_scheduler #(
  parameter int HOST_MAX_WAIT = 8,
  parameter int WAIT_W        = 4
) (
  input logic                clk,
  input logic                rst_n,
  wb_port_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SECOND = 2'd1,
    HALT   = 2'd2
  } state_e;

  localparam logic [3:0]        NONE     = 4'hF;
  localparam logic [2:0]        AOK      = 3'd1;
  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(HOST_MAX_WAIT);

  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [3:0]        rf_waddr_q, rf_waddr_d;
  logic [63:0]       rf_wdata_q, rf_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              halted_q, halted_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        m_addr_q, m_addr_d;
  logic [63:0]       m_data_q, m_data_d;

  logic host_pend;
  logic host_force;
  logic grant;
  logic w_acc;
  logic e_ok;
  logic m_ok;

  assign e_ok = (bus.W_icode inside {4'd2, 4'd3, 4'd6, 4'd8,
                                     4'd9, 4'd10, 4'd11})
              && (bus.W_dstE != NONE);
  assign m_ok = (bus.W_icode inside {4'd5, 4'd11})
              && (bus.W_dstM != NONE);

  // a request still high during its own ack cycle is the one just served
  assign host_pend  = bus.host_req && !host_ack_q;
  assign host_force = host_pend && (wait_q >= MAX_WAIT);

  assign bus.w_ready = rst_n && (state_q == RUN) && !host_force;
  assign w_acc       = bus.W_valid && bus.w_ready;

  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    host_ack_d = 1'b0;
    halted_d   = halted_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    wait_d     = wait_q;
    grant      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (host_force) begin
          grant = 1'b1;
        end else if (w_acc && bus.W_stat != AOK) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (w_acc && e_ok && m_ok &&
                     bus.W_dstE != bus.W_dstM) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.W_dstE;
          rf_wdata_d = bus.W_valE;
          m_addr_d   = bus.W_dstM;
          m_data_d   = bus.W_valM;
          state_d    = SECOND;
        end else if (w_acc && m_ok) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.W_dstM;
          rf_wdata_d = bus.W_valM;
        end else if (w_acc && e_ok) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.W_dstE;
          rf_wdata_d = bus.W_valE;
        end else if (host_pend) begin
          grant = 1'b1;
        end
      end
      SECOND: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = m_addr_q;
        rf_wdata_d = m_data_q;
        state_d    = RUN;
      end
      HALT: begin
        grant = host_pend;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (grant) begin
      host_ack_d = 1'b1;
      if (bus.host_addr != NONE) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.host_addr;
        rf_wdata_d = bus.host_data;
      end
    end
    if (!host_pend || grant) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      host_ack_q <= 1'b0;
      halted_q   <= 1'b0;
      wait_q     <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      host_ack_q <= host_ack_d;
      halted_q   <= halted_d;
      wait_q     <= wait_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.host_ack = host_ack_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: directed scenarios plus a randomized
// write-order scoreboard for wb_port_scheduler.
module tb_wb_port_scheduler;

  localparam int HMW = 8;
  localparam logic [3:0] NONE = 4'hF;

  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_port_scheduler_if bus ();

  wb_port_scheduler #(
    .HOST_MAX_WAIT(HMW),
    .WAIT_W       (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.W_valid   = 1'b0;
    bus.W_stat    = 3'd1;
    bus.W_icode   = 4'd0;
    bus.W_dstE    = NONE;
    bus.W_dstM    = NONE;
    bus.W_valE    = '0;
    bus.W_valM    = '0;
    bus.host_req  = 1'b0;
    bus.host_addr = '0;
    bus.host_data = '0;
  endtask

  task automatic drive_w(input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
    bus.W_valid = 1'b1;
    bus.W_stat  = st;
    bus.W_icode = ic;
    bus.W_dstE  = de;
    bus.W_dstM  = dm;
    bus.W_valE  = ve;
    bus.W_valM  = vm;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic e_elig(input logic [3:0] ic, input logic [3:0] d);
    return (ic inside {4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) && d != NONE;
  endfunction

  function automatic logic m_elig(input logic [3:0] ic, input logic [3:0] d);
    return (ic inside {4'd5, 4'd11}) && d != NONE;
  endfunction

  task automatic test_reset();
    idle_inputs();
    bus.W_valid = 1'b1;
    rst_n = 1'b0;
    step();
    #1;
    checks++;
    if (bus.w_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_w_ready: got %b want 0", bus.w_ready);
    end
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 4'd0 || bus.rf_wdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_rf: got we=%b a=%h d=%h want 0/0/0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    checks++;
    if (bus.host_ack !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got ack=%b halted=%b want 0/0",
               bus.host_ack, bus.halted);
    end
    bus.W_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_irmovq();
    drive_w(3'd1, 4'd3, 4'd2, NONE, 64'h1234, 64'h0);
    #1;
    checks++;
    if (bus.w_ready !== 1'b1) begin
      errors++;
      $display("FAIL irmovq_ready: got %b want 1", bus.w_ready);
    end
    step();
    bus.W_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd2 || bus.rf_wdata !== 64'h1234) begin
      errors++;
      $display("FAIL irmovq_write: got we=%b a=%h d=%h want 1/2/1234",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL irmovq_idle: got we=%b want 0", bus.rf_we);
    end
  endtask

  task automatic test_popq();
    drive_w(3'd1, 4'd11, 4'd4, 4'd3, 64'h100, 64'hAB);
    step();
    bus.W_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd4 || bus.rf_wdata !== 64'h100) begin
      errors++;
      $display("FAIL popq_e: got we=%b a=%h d=%h want 1/4/100",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    #1;
    checks++;
    if (bus.w_ready !== 1'b0) begin
      errors++;
      $display("FAIL popq_stall: got w_ready=%b want 0", bus.w_ready);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd3 || bus.rf_wdata !== 64'hAB) begin
      errors++;
      $display("FAIL popq_m: got we=%b a=%h d=%h want 1/3/ab",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    #1;
    checks++;
    if (bus.w_ready !== 1'b1) begin
      errors++;
      $display("FAIL popq_resume: got w_ready=%b want 1", bus.w_ready);
    end
    step();
  endtask

  task automatic test_popq_rsp();
    drive_w(3'd1, 4'd11, 4'd4, 4'd4, 64'h100, 64'h55);
    step();
    bus.W_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd4 || bus.rf_wdata !== 64'h55) begin
      errors++;
      $display("FAIL popq_rsp_write: got we=%b a=%h d=%h want 1/4/55",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    #1;
    checks++;
    if (bus.w_ready !== 1'b1) begin
      errors++;
      $display("FAIL popq_rsp_ready: got %b want 1", bus.w_ready);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL popq_rsp_single: got we=%b want 0", bus.rf_we);
    end
  endtask

  task automatic test_host_starve();
    int n = 0;
    bus.host_req  = 1'b1;
    bus.host_addr = 4'd7;
    bus.host_data = 64'hDEAD;
    while (n < 20) begin
      drive_w(3'd1, 4'd3, 4'(n % 8), NONE, 64'(n) + 64'h500, 64'h0);
      #1;
      if (!bus.w_ready) break;
      step();
      checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'(n % 8) ||
          bus.rf_wdata !== 64'(n) + 64'h500 || bus.host_ack !== 1'b0) begin
        errors++;
        $display("FAIL stream_write %0d: got we=%b a=%h d=%h ack=%b",
                 n, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.host_ack);
      end
      n++;
    end
    checks++;
    if (n != HMW) begin
      errors++;
      $display("FAIL host_defer: got %0d accepted before preempt want %0d", n, HMW);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd7 ||
        bus.rf_wdata !== 64'hDEAD || bus.host_ack !== 1'b1) begin
      errors++;
      $display("FAIL host_force: got we=%b a=%h d=%h ack=%b want 1/7/dead/1",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.host_ack);
    end
    bus.host_req = 1'b0;
    #1;
    checks++;
    if (bus.w_ready !== 1'b1) begin
      errors++;
      $display("FAIL host_resume: got w_ready=%b want 1", bus.w_ready);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'(n % 8) ||
        bus.rf_wdata !== 64'(n) + 64'h500 || bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL held_instr: got we=%b a=%h d=%h ack=%b",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.host_ack);
    end
    bus.W_valid = 1'b0;
    step();
  endtask

  task automatic test_halt();
    drive_w(3'd2, 4'd5, NONE, 4'd1, 64'h0, 64'h99);
    step();
    drive_w(3'd1, 4'd3, 4'd6, NONE, 64'h66, 64'h0);
    checks++;
    if (bus.rf_we !== 1'b0 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: got we=%b halted=%b want 0/1",
               bus.rf_we, bus.halted);
    end
    #1;
    checks++;
    if (bus.w_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_ready: got %b want 0", bus.w_ready);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignore: got we=%b want 0", bus.rf_we);
    end
    bus.host_req  = 1'b1;
    bus.host_addr = 4'd5;
    bus.host_data = 64'h77;
    step();
    bus.host_req = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd5 ||
        bus.rf_wdata !== 64'h77 || bus.host_ack !== 1'b1) begin
      errors++;
      $display("FAIL halt_host: got we=%b a=%h d=%h ack=%b want 1/5/77/1",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.host_ack);
    end
    step();
    checks++;
    if (bus.host_ack !== 1'b0 || bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL host_ack_pulse: got ack=%b we=%b want 0/0",
               bus.host_ack, bus.rf_we);
    end
    bus.host_req  = 1'b1;
    bus.host_addr = NONE;
    bus.host_data = 64'h1;
    step();
    bus.host_req = 1'b0;
    checks++;
    if (bus.host_ack !== 1'b1 || bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL host_addr_f: got ack=%b we=%b want 1/0",
               bus.host_ack, bus.rf_we);
    end
    bus.W_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_popq();
    do_reset();
    drive_w(3'd1, 4'd11, 4'd6, 4'd9, 64'h600, 64'h900);
    step();
    bus.W_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd6 || bus.rf_wdata !== 64'h600) begin
      errors++;
      $display("FAIL rstpop_e: got we=%b a=%h d=%h want 1/6/600",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.halted !== 1'b0 || bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstpop_clear: got we=%b halted=%b ack=%b want 0/0/0",
               bus.rf_we, bus.halted, bus.host_ack);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.w_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstpop_run: got w_ready=%b want 1", bus.w_ready);
    end
    step();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++;
      $display("FAIL rstpop_no_m: got we=%b a=%h want 0", bus.rf_we, bus.rf_waddr);
    end
  endtask

  task automatic test_random();
    wr_t         q[$];
    logic        hpend = 1'b0;
    logic        just_acked;
    logic [3:0]  ha = '0;
    logic [63:0] hd = '0;
    int          age = 0;
    logic        w_hold = 1'b0;
    wr_t         w;
    do_reset();
    for (int c = 0; c < 3040; c++) begin
      just_acked = 1'b0;
      if (bus.host_ack === 1'b1) begin
        checks++;
        if (!hpend || q.size() != 0 || bus.rf_we !== (ha != NONE) ||
            (ha != NONE && (bus.rf_waddr !== ha || bus.rf_wdata !== hd))) begin
          errors++;
          $display("FAIL rand_host c=%0d: got we=%b a=%h d=%h want a=%h d=%h pend=%b q=%0d",
                   c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, ha, hd, hpend, q.size());
        end
        hpend = 1'b0;
        age = 0;
        just_acked = 1'b1;
        bus.host_req = 1'b0;
      end else if (q.size() > 0) begin
        w = q.pop_front();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== w.a || bus.rf_wdata !== w.d) begin
          errors++;
          $display("FAIL rand_w c=%0d: got we=%b a=%h d=%h want 1/%h/%h",
                   c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, w.a, w.d);
        end
      end else begin
        checks++;
        if (bus.rf_we !== 1'b0) begin
          errors++;
          $display("FAIL rand_spurious c=%0d: got we=%b a=%h want 0",
                   c, bus.rf_we, bus.rf_waddr);
        end
      end
      if (hpend) begin
        age++;
        checks++;
        if (age > HMW + 2) begin
          errors++;
          $display("FAIL rand_host_wait c=%0d: got age %0d want <= %0d", c, age, HMW + 2);
        end
      end
      if (!w_hold) begin
        if (c < 3000 && $urandom_range(0, 3) != 0) begin
          drive_w(3'd1, 4'($urandom_range(0, 11)),
                  ($urandom_range(0, 7) == 0) ? NONE : 4'($urandom_range(0, 14)),
                  ($urandom_range(0, 7) == 0) ? NONE : 4'($urandom_range(0, 14)),
                  {$urandom, $urandom}, {$urandom, $urandom});
        end else begin
          bus.W_valid = 1'b0;
        end
      end
      if (c < 3000 && !hpend && !just_acked && $urandom_range(0, 5) == 0) begin
        hpend = 1'b1;
        ha = ($urandom_range(0, 9) == 0) ? NONE : 4'($urandom_range(0, 14));
        hd = {$urandom, $urandom};
        bus.host_req  = 1'b1;
        bus.host_addr = ha;
        bus.host_data = hd;
      end
      #1;
      if (bus.W_valid && bus.w_ready) begin
        if (e_elig(bus.W_icode, bus.W_dstE) && m_elig(bus.W_icode, bus.W_dstM)) begin
          if (bus.W_dstE != bus.W_dstM) q.push_back('{bus.W_dstE, bus.W_valE});
          q.push_back('{bus.W_dstM, bus.W_valM});
        end else if (e_elig(bus.W_icode, bus.W_dstE)) begin
          q.push_back('{bus.W_dstE, bus.W_valE});
        end else if (m_elig(bus.W_icode, bus.W_dstM)) begin
          q.push_back('{bus.W_dstM, bus.W_valM});
        end
        w_hold = 1'b0;
      end else begin
        w_hold = bus.W_valid;
      end
      step();
    end
    checks++;
    if (q.size() != 0 || hpend || w_hold) begin
      errors++;
      $display("FAIL rand_drain: got q=%0d hpend=%b hold=%b want 0/0/0",
               q.size(), hpend, w_hold);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_irmovq();
    test_popq();
    test_popq_rsp();
    test_host_starve();
    test_halt();
    test_reset_mid_popq();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
